koa_mult_arbiter: RTL

Shares one Karatsuba significand multiplier (`KOA_c`, combinational) between two requesters, e.g. the FP multiply unit and the fused-op path. It registers operands, adds a fixed product pipeline, and tracks result ownership with a tag shift register. Each requester gets its own credit-managed result FIFO. It sits between the FPU operand-staging logic and the `KOA_c` instance, so two clients can issue back-to-back into a single multiplier array.

---
 rtl/koa_arb_pkg.sv | 23 ++
 rtl/KOA_c.sv | 31 +++
 rtl/koa_res_fifo.sv | 46 ++++
 rtl/koa_mult_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/koa_arb_pkg.sv
// Shared types for the Karatsuba multiplier arbiter: requester ids, pipeline stage record, credit sizing.
// The stage record is sized for the default significand width; the arbiter's SW must match KOA_SW.
package koa_arb_pkg;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    localparam int KOA_SW = 54;
    localparam int KOA_PW = 2 * KOA_SW;

    typedef struct packed {
        logic                vld;
        req_id_t             tag;
        logic [KOA_PW-1:0]   prod;
    } stage_t;

    function automatic int cred_w(input int fdepth);
        return $clog2(fdepth + 1);
    endfunction

endpackage

// File: rtl/KOA_c.sv
// Combinational significand multiplier: one Karatsuba split when depth > 0, schoolbook otherwise.
// Zero latency, no flow control; the exact 2*SW product is produced every cycle.
module KOA_c #(
    parameter int SW        = 54,
    parameter int precision = 1,
    parameter int depth     = 3
) (
    input  logic [SW-1:0]   Data_A_i,
    input  logic [SW-1:0]   Data_B_i,
    output logic [2*SW-1:0] sgf_result_o
);

    localparam int PW = 2 * SW;
    localparam int L  = SW - SW / 2;

    if (depth > 0 && precision >= 0) begin : g_kara
        logic [PW-1:0] al, ah, bl, bh, z0, z1, z2;
        assign al = PW'(Data_A_i[L-1:0]);
        assign ah = PW'(Data_A_i[SW-1:L]);
        assign bl = PW'(Data_B_i[L-1:0]);
        assign bh = PW'(Data_B_i[SW-1:L]);
        assign z0 = al * bl;
        assign z2 = ah * bh;
        // Middle term recovered from the cross-sum product; exact modulo 2^PW.
        assign z1 = (al + ah) * (bl + bh) - z0 - z2;
        assign sgf_result_o = (z2 << (2 * L)) + (z1 << L) + z0;
    end else begin : g_school
        assign sgf_result_o = PW'(Data_A_i) * PW'(Data_B_i);
    end

endmodule

// File: rtl/koa_res_fifo.sv
// Per-requester result FIFO: a push is readable at the head the cycle after it is written.
// Never refuses a push (upstream credits prevent overflow); pop is ignored when empty.
module koa_res_fifo #(
    parameter int W     = 108,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         vld,
    output logic [W-1:0] dat
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          pop_ok;

    assign pop_ok = pop && (cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop_ok)      cnt <= cnt + CW'(1);
            else if (!push && pop_ok) cnt <= cnt - CW'(1);
        end
    end

    assign vld = (cnt != '0);
    assign dat = mem[rd_ptr];

endmodule

// File: rtl/koa_mult_arbiter.sv
// Two-requester front end for one KOA_c multiplier; results land in the owner's FIFO LAT cycles after issue.
// Backpressure only via per-requester credits (no downstream stall); KOA_ARB_RR_EN selects round-robin ties.
module koa_mult_arbiter
    import koa_arb_pkg::*;
#(
    parameter int SW        = KOA_SW,
    parameter int PRECISION = 1,
    parameter int DEPTH     = 3,
    parameter int LAT       = 2,
    parameter int FDEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid_i,
    output logic            a_ready_o,
    input  logic [SW-1:0]   a_op_a_i,
    input  logic [SW-1:0]   a_op_b_i,
    input  logic            b_valid_i,
    output logic            b_ready_o,
    input  logic [SW-1:0]   b_op_a_i,
    input  logic [SW-1:0]   b_op_b_i,
    output logic            a_res_valid_o,
    output logic [2*SW-1:0] a_res_o,
    input  logic            a_res_ready_i,
    output logic            b_res_valid_o,
    output logic [2*SW-1:0] b_res_o,
    input  logic            b_res_ready_i,
    output logic            busy_o
);

    localparam int PW = 2 * SW;
    localparam int CW = cred_w(FDEPTH);

    logic [CW-1:0] a_cred, b_cred, a_cred_d, b_cred_d;
    logic          a_elig, b_elig, a_gnt, b_gnt, a_pop, b_pop;
    logic          s0_vld;
    req_id_t       s0_tag;
    logic [SW-1:0] s0_a, s0_b;
    logic [PW-1:0] prod0;
    stage_t        last;

    assign a_elig = a_valid_i && (a_cred != '0);
    assign b_elig = b_valid_i && (b_cred != '0);

`ifdef KOA_ARB_RR_EN
    req_id_t ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       ptr <= REQ_A;
        else if (a_gnt) ptr <= REQ_B;
        else if (b_gnt) ptr <= REQ_A;
    end
`endif

    always_comb begin
        a_gnt = a_elig;
        b_gnt = b_elig;
        if (a_elig && b_elig) begin
`ifdef KOA_ARB_RR_EN
            a_gnt = (ptr == REQ_A);
            b_gnt = (ptr == REQ_B);
`else
            b_gnt = 1'b0;
`endif
        end
    end

    assign a_ready_o = a_gnt;
    assign b_ready_o = b_gnt;
    assign a_pop     = a_res_valid_o && a_res_ready_i;
    assign b_pop     = b_res_valid_o && b_res_ready_i;

    always_comb begin
        a_cred_d = a_cred;
        b_cred_d = b_cred;
        if (a_gnt && !a_pop)      a_cred_d = a_cred - CW'(1);
        else if (!a_gnt && a_pop) a_cred_d = a_cred + CW'(1);
        if (b_gnt && !b_pop)      b_cred_d = b_cred - CW'(1);
        else if (!b_gnt && b_pop) b_cred_d = b_cred + CW'(1);
    end

    // Outstanding work is exactly the credits that are out, so busy follows them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_cred <= CW'(FDEPTH);
            b_cred <= CW'(FDEPTH);
            busy_o <= 1'b0;
        end else begin
            a_cred <= a_cred_d;
            b_cred <= b_cred_d;
            busy_o <= (a_cred_d != CW'(FDEPTH)) || (b_cred_d != CW'(FDEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_vld <= 1'b0;
            s0_tag <= REQ_A;
            s0_a   <= '0;
            s0_b   <= '0;
        end else begin
            s0_vld <= a_gnt || b_gnt;
            s0_tag <= b_gnt ? REQ_B : REQ_A;
            if (a_gnt) begin
                s0_a <= a_op_a_i;
                s0_b <= a_op_b_i;
            end else if (b_gnt) begin
                s0_a <= b_op_a_i;
                s0_b <= b_op_b_i;
            end
        end
    end

    KOA_c #(
        .SW        (SW),
        .precision (PRECISION),
        .depth     (DEPTH)
    ) u_koa (
        .Data_A_i     (s0_a),
        .Data_B_i     (s0_b),
        .sgf_result_o (prod0)
    );

    if (LAT == 1) begin : g_direct
        assign last = '{vld: s0_vld, tag: s0_tag, prod: prod0};
    end else begin : g_pipe
        stage_t pipe [1:LAT-1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 1; i < LAT; i++) pipe[i] <= '0;
            end else begin
                pipe[1] <= '{vld: s0_vld, tag: s0_tag, prod: prod0};
                for (int i = 2; i < LAT; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign last = pipe[LAT-1];
    end

    koa_res_fifo #(.W(PW), .DEPTH(FDEPTH)) u_fifo_a (
        .clk      (clk),
        .rst      (rst),
        .push     (last.vld && (last.tag == REQ_A)),
        .push_dat (last.prod),
        .pop      (a_pop),
        .vld      (a_res_valid_o),
        .dat      (a_res_o)
    );

    koa_res_fifo #(.W(PW), .DEPTH(FDEPTH)) u_fifo_b (
        .clk      (clk),
        .rst      (rst),
        .push     (last.vld && (last.tag == REQ_B)),
        .push_dat (last.prod),
        .pop      (b_pop),
        .vld      (b_res_valid_o),
        .dat      (b_res_o)
    );

endmodule
